// File: rtl/gpr_wb_pkg.sv
// Shared types for the GPR writeback arbiter and its result FIFO.
package gpr_wb_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t addr;
    word_t     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_LU
  } wb_src_e;

  // One-hot decode of a register number, used to build the pending mask.
  function automatic logic [31:0] addr_onehot(input reg_addr_t a);
    return 32'h1 << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. Every slot and its valid bit are
// exposed so the parent can build the pending-destination mask.
module wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  wb_entry_t                 push_entry_i,
  input  logic                      pop_i,
  output wb_entry_t                 head_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output wb_entry_t [DEPTH-1:0]     entries_o,
  output logic [DEPTH-1:0]          valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      vld_q;
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Occupancy bookkeeping; push and pop are pre-qualified by the parent.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, count and per-slot valid bits; pointers wrap as DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) begin
        wr_q        <= wr_q + PW'(1);
        vld_q[wr_q] <= 1'b1;
      end
      if (pop_i) begin
        rd_q        <= rd_q + PW'(1);
        vld_q[rd_q] <= 1'b0;
      end
    end
  end

  // Payload storage; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else if (push_i) mem_q[wr_q] <= push_entry_i;
  end

  assign head_o    = mem_q[rd_q];
  assign count_o   = cnt_q;
  assign entries_o = mem_q;
  assign valid_o   = vld_q;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a FIFO and drain on idle cycles or when starved.
// Optional macro GPR_WB_TRACE_EN adds a simulation trace of issued writes.
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [4:0]             pipe_addr,
  input  logic [31:0]            pipe_data,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [4:0]             lu_addr,
  input  logic [31:0]            lu_data,
  output logic                   pipe_stall,
  output logic [31:0]            busy_mask,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   RegWrite,
  output logic [4:0]             A3,
  output logic [31:0]            Wd
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [CW-1:0]         count;
  logic                  empty, push, pop;
  wb_src_e               src;

  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  regwrite_q;
  reg_addr_t             a3_q;
  word_t                 wd_q;

  // Ready depends only on registered occupancy, so a full FIFO never
  // accepts even when it drains in the same cycle.
  assign empty    = (count == '0);
  assign lu_ready = (count < CW'(DEPTH));
  assign push     = lu_valid && lu_ready && (lu_addr != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i ('{addr: lu_addr, data: lu_data}),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .entries_o    (entries),
    .valid_o      (valid)
  );

  assign pipe_stall = (wait_cnt_q == WW'(MAX_WAIT));

  // Grant: a forced drain beats the pipeline, zero-register pipeline writes are dropped.
  always_comb begin
    src = WB_NONE;
    if (pipe_stall)                          src = empty ? WB_NONE : WB_LU;
    else if (pipe_we && (pipe_addr != '0))   src = WB_PIPE;
    else if (!empty)                         src = WB_LU;
  end

  assign pop = (src == WB_LU);

  // Starvation count restarts whenever the head issues or nothing is queued.
  always_comb begin
    wait_cnt_d = wait_cnt_q + WW'(1);
    if (empty || pop) wait_cnt_d = '0;
  end

  // Pending destinations: every live FIFO slot marks its register.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i]) busy_mask |= addr_onehot(entries[i].addr);
    busy_mask[0] = 1'b0;
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  // GPR write port registers; address and data hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      a3_q       <= '0;
      wd_q       <= '0;
    end else begin
      regwrite_q <= (src != WB_NONE);
      case (src)
        WB_PIPE: begin
          a3_q <= pipe_addr;
          wd_q <= pipe_data;
        end
        WB_LU: begin
          a3_q <= head.addr;
          wd_q <= head.data;
        end
        default: ;
      endcase
    end
  end

  assign RegWrite   = regwrite_q;
  assign A3         = a3_q;
  assign Wd         = wd_q;
  assign fifo_count = count;

`ifdef GPR_WB_TRACE_EN
  // Simulation trace of each write as it is granted.
  always @(posedge clk) begin
    if (!rst) begin
      if (src == WB_PIPE) $display("WB -- PIPE: %d <- %h", pipe_addr, pipe_data);
      if (src == WB_LU)   $display("WB -- LU: %d <- %h", head.addr, head.data);
      if (pipe_stall)     $display("WB -- stall: forced LU drain, pipeline held");
    end
  end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for starvation, full-FIFO and reset.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        pipe_stall;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;
  logic        RegWrite;
  logic [4:0]  A3;
  logic [31:0] Wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_addr    (lu_addr),
    .lu_data    (lu_data),
    .pipe_stall (pipe_stall),
    .busy_mask  (busy_mask),
    .fifo_count (fifo_count),
    .RegWrite   (RegWrite),
    .A3         (A3),
    .Wd         (Wd)
  );

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        rw;
    logic [4:0]  a3;
    logic [31:0] wd;
    int          cnt;
    logic [31:0] mask;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
  endtask

  task automatic chk_out(input string nm, input logic rw, input logic [4:0] a3,
                         input logic [31:0] wd, input int cnt, input logic [31:0] mask,
                         input logic stall);
    chk({nm, ".RegWrite"}, 32'(RegWrite), 32'(rw));
    chk({nm, ".A3"}, 32'(A3), 32'(a3));
    chk({nm, ".Wd"}, Wd, wd);
    chk({nm, ".count"}, 32'(fifo_count), 32'(cnt));
    chk({nm, ".busy"}, busy_mask, mask);
    chk({nm, ".stall"}, 32'(pipe_stall), 32'(stall));
  endtask

  initial begin
    // Each row: inputs for one cycle, then outputs seen after that edge.
    //          pwe pa  pd            lv la  ld            rw a3  wd            cnt mask
    tbl[0]  = '{1, 5,  32'h1234,     0, 0,  32'h0,        1, 5,  32'h1234,     0, 32'h0};
    tbl[1]  = '{1, 0,  32'hFFFF,     0, 0,  32'h0,        0, 5,  32'h1234,     0, 32'h0};
    tbl[2]  = '{0, 0,  32'h0,        1, 7,  32'hAAAA,     0, 5,  32'h1234,     1, 32'h0000_0080};
    tbl[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  32'hAAAA,     0, 32'h0};
    tbl[4]  = '{1, 3,  32'h33,       1, 9,  32'h1,        1, 3,  32'h33,       1, 32'h0000_0200};
    tbl[5]  = '{1, 4,  32'h44,       1, 9,  32'h2,        1, 4,  32'h44,       2, 32'h0000_0200};
    tbl[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  32'h1,        1, 32'h0000_0200};
    tbl[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  32'h2,        0, 32'h0};
    tbl[8]  = '{0, 0,  32'h0,        1, 0,  32'hDEAD,     0, 9,  32'h2,        0, 32'h0};
    tbl[9]  = '{1, 0,  32'h0,        1, 12, 32'hC,        0, 9,  32'h2,        1, 32'h0000_1000};
    tbl[10] = '{1, 0,  32'h0,        0, 0,  32'h0,        1, 12, 32'hC,        0, 32'h0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    chk_out("reset", 0, 0, 32'h0, 0, 32'h0, 0);
    rst = 1'b0;
    #1;
    chk("reset.lu_ready", 32'(lu_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la, tbl[i].ld);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].rw, tbl[i].a3, tbl[i].wd, tbl[i].cnt, tbl[i].mask, 0);
      chk($sformatf("row%0d.lu_ready", i), 32'(lu_ready), 32'd1);
    end

    // Fill the FIFO while the pipeline writes every cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h100 + 32'(k), 1, 5'(20 + k), 32'hA0 + 32'(k));
      step();
      chk_out($sformatf("fill%0d", k), 1, 1, 32'h100 + 32'(k), k + 1,
              (32'h1 << (k + 1)) - 1 << 20, 0);
    end
    chk("full.lu_ready", 32'(lu_ready), 32'd0);

    // Head has lost 3 cycles; 4 more keep the stall off, the 5th raises it.
    drive(1, 1, 32'h103, 1, 25, 32'hBAD);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out($sformatf("starve%0d", k), 1, 1, 32'h103, 4, 32'h00F0_0000, (k == 4));
    end

    // Stall cycle: head drains, full FIFO refuses the concurrent LU push.
    step();
    chk_out("drain", 1, 20, 32'hA0, 3, 32'h00E0_0000, 0);
    chk("drain.lu_ready", 32'(lu_ready), 32'd1);

    // Held pipeline write goes through on the cycle after the forced drain.
    drive(1, 1, 32'h777, 0, 0, 0);
    step();
    chk_out("pipe_after_stall", 1, 1, 32'h777, 3, 32'h00E0_0000, 0);

    // Remaining entries issue in accept order once the pipeline goes idle.
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("order%0d", k), 1, 5'(21 + k), 32'hA1 + 32'(k), 2 - k,
              k == 2 ? 32'h0 : ((32'h1 << (2 - k)) - 1) << (22 + k), 0);
    end

    // Asynchronous reset mid-operation with three queued entries.
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 32'h55, 1, 5'(10 + k), 32'hB0 + 32'(k));
      step();
    end
    chk("pre_rst.count", 32'(fifo_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst.lu_ready", 32'(lu_ready), 32'd1);
    drive(1, 6, 32'hCAFE, 0, 0, 0);
    step();
    chk_out("post_rst_write", 1, 6, 32'hCAFE, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
